// File: rtl/h264_wb_pkg.sv
// h264_wb_pkg: shared types, word counts and pixel packing for the macroblock writeback path
package h264_wb_pkg;
    typedef enum logic [2:0] {IDLE, WR_Y, WR_U, WR_V, DONE} wb_state_t;
    typedef enum logic [1:0] {PL_Y, PL_U, PL_V} wb_plane_t;
    localparam int Y_WORDS = 64;
    localparam int C_WORDS = 16;
    // leftmost pixel lands in the low byte of the bus word
    function automatic logic [31:0] pack_px(input logic [3:0][7:0] px);
        return {px[3], px[2], px[1], px[0]};
    endfunction
endpackage

// File: rtl/h264_wb_addr_gen.sv
// h264_wb_addr_gen: planar YUV 4:2:0 byte address of one 32-bit word in a macroblock
module h264_wb_addr_gen import h264_wb_pkg::*; #(
    parameter int          FRAME_W_MB = 22,
    parameter logic [31:0] BASE_Y     = 32'h0000_0000,
    parameter logic [31:0] BASE_U     = 32'h0001_8C00,
    parameter logic [31:0] BASE_V     = 32'h0001_EF00
) (
    input  wb_plane_t   i_plane,
    input  logic [5:0]  i_mb_x,
    input  logic [5:0]  i_mb_y,
    input  logic [3:0]  i_row,
    input  logic [1:0]  i_word,
    output logic [31:0] o_addr
);
    logic        w_luma;
    logic [31:0] w_line, w_col, w_pitch, w_base;
    always_comb begin
        w_luma  = i_plane == PL_Y;
        w_line  = w_luma ? {22'd0, i_mb_y, 4'd0} + {28'd0, i_row} : {23'd0, i_mb_y, 3'd0} + {28'd0, i_row};
        w_col   = w_luma ? {22'd0, i_mb_x, 4'd0} : {23'd0, i_mb_x, 3'd0};
        w_pitch = w_luma ? 32'(FRAME_W_MB * 16) : 32'(FRAME_W_MB * 8);
        w_base  = w_luma ? BASE_Y : (i_plane == PL_U) ? BASE_U : BASE_V;
        o_addr  = w_base + w_line * w_pitch + w_col + {28'd0, i_word, 2'b00};
    end
endmodule

// File: rtl/h264_mb_writeback.sv
// h264_mb_writeback: writes one reconstructed macroblock (Y, Cb, Cr) to the frame buffer as 32-bit words
// Optional H264_WB_FRAME_DONE_EN adds frame_done_o, pulsed with mb_done_o for the last MB of the frame.
module h264_mb_writeback import h264_wb_pkg::*; #(
    parameter int          FRAME_W_MB = 22,
    parameter int          FRAME_H_MB = 18,
    parameter logic [31:0] BASE_Y     = 32'h0000_0000,
    parameter logic [31:0] BASE_U     = 32'h0001_8C00,
    parameter logic [31:0] BASE_V     = 32'h0001_EF00
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mb_valid_i,
    output logic                    mb_ready_o,
    input  logic [5:0]              mb_x_i,
    input  logic [5:0]              mb_y_i,
    input  logic [15:0][15:0][7:0]  matrixY_i,
    input  logic [7:0][7:0][7:0]    matrixU_i,
    input  logic [7:0][7:0][7:0]    matrixV_i,
    output logic                    wr_valid_o,
    input  logic                    wr_ready_i,
    output logic [31:0]             wr_addr_o,
    output logic [31:0]             wr_data_o,
`ifdef H264_WB_FRAME_DONE_EN
    output logic                    frame_done_o,
`endif
    output logic                    mb_done_o
);
    if (FRAME_W_MB > 64 || FRAME_H_MB > 64) begin : g_bad_cfg
        $error("frame size exceeds 6-bit macroblock coordinates");
    end

    wb_state_t              r_state, w_next;
    logic                   r_ready;
    logic [5:0]             r_cnt, r_mb_x, r_mb_y;
    logic [15:0][15:0][7:0] r_y;
    logic [7:0][7:0][7:0]   r_u, r_v;
    logic                   w_accept, w_xfer, w_last;
    wb_plane_t              w_plane;
    logic [3:0]             w_row;
    logic [1:0]             w_word;
    logic [31:0]            w_addr, w_data;

    assign w_accept   = mb_valid_i && r_ready;
    assign w_xfer     = wr_valid_o && wr_ready_i;
    assign mb_ready_o = r_ready;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_y    <= matrixY_i;
            r_u    <= matrixU_i;
            r_v    <= matrixV_i;
            r_mb_x <= mb_x_i;
            r_mb_y <= mb_y_i;
        end
    end

    // r_cnt is the word index within the current plane; it restarts at each plane boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= w_next == IDLE;
            r_cnt   <= w_xfer ? (w_last ? 6'd0 : r_cnt + 6'd1) : r_cnt;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? WR_Y : IDLE;
            WR_Y:    w_next = (w_xfer && w_last) ? WR_U : WR_Y;
            WR_U:    w_next = (w_xfer && w_last) ? WR_V : WR_U;
            WR_V:    w_next = (w_xfer && w_last) ? DONE : WR_V;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        wr_valid_o = r_state inside {WR_Y, WR_U, WR_V};
        mb_done_o  = r_state == DONE;
        w_plane    = (r_state == WR_U) ? PL_U : (r_state == WR_V) ? PL_V : PL_Y;
        w_last     = (w_plane == PL_Y) ? r_cnt == 6'(Y_WORDS - 1) : r_cnt[3:0] == 4'(C_WORDS - 1);
        w_row      = (w_plane == PL_Y) ? r_cnt[5:2] : {1'b0, r_cnt[3:1]};
        w_word     = (w_plane == PL_Y) ? r_cnt[1:0] : {1'b0, r_cnt[0]};
        w_data     = pack_px((w_plane == PL_Y) ? r_y[w_row][{w_word, 2'b00} +: 4] :
                             (w_plane == PL_U) ? r_u[w_row[2:0]][{w_word[0], 2'b00} +: 4] :
                                                 r_v[w_row[2:0]][{w_word[0], 2'b00} +: 4]);
        wr_addr_o  = wr_valid_o ? w_addr : 32'd0;
        wr_data_o  = wr_valid_o ? w_data : 32'd0;
    end

`ifdef H264_WB_FRAME_DONE_EN
    assign frame_done_o = (r_state == DONE) && r_mb_x == 6'(FRAME_W_MB - 1) && r_mb_y == 6'(FRAME_H_MB - 1);
`endif

    h264_wb_addr_gen #(
        .FRAME_W_MB (FRAME_W_MB),
        .BASE_Y     (BASE_Y),
        .BASE_U     (BASE_U),
        .BASE_V     (BASE_V)
    ) u_addr (
        .i_plane (w_plane),
        .i_mb_x  (r_mb_x),
        .i_mb_y  (r_mb_y),
        .i_row   (w_row),
        .i_word  (w_word),
        .o_addr  (w_addr)
    );
endmodule

// File: tb/tb_h264_mb_writeback.sv
// tb_h264_mb_writeback: directed checks of word order, addresses, latency, backpressure, busy-ignore and abort
module tb_h264_mb_writeback;
    logic clk = 0, rst = 1, mb_valid_i = 0, wr_ready_i = 0;
    logic [5:0] mb_x_i = 0, mb_y_i = 0;
    logic [15:0][15:0][7:0] dy;
    logic [7:0][7:0][7:0] du, dv;
    logic mb_ready_o, wr_valid_o, mb_done_o;
    logic [31:0] wr_addr_o, wr_data_o;
`ifdef H264_WB_FRAME_DONE_EN
    logic frame_done_o;
`endif

    h264_mb_writeback dut (
        .clk        (clk),
        .rst        (rst),
        .mb_valid_i (mb_valid_i),
        .mb_ready_o (mb_ready_o),
        .mb_x_i     (mb_x_i),
        .mb_y_i     (mb_y_i),
        .matrixY_i  (dy),
        .matrixU_i  (du),
        .matrixV_i  (dv),
        .wr_valid_o (wr_valid_o),
        .wr_ready_i (wr_ready_i),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
`ifdef H264_WB_FRAME_DONE_EN
        .frame_done_o (frame_done_o),
`endif
        .mb_done_o  (mb_done_o)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    int acc_cyc = 0, done_cnt = 0, done_cyc = 0, fd_cnt = 0, fd_cyc = 0, stall_err = 0;
    logic [31:0] q_a[$], q_d[$];
    int q_c[$];
    logic pv = 0, pr = 0;
    logic [31:0] pa = 0, pd = 0;
    logic [7:0] ey[16][16], eu[8][8], ev[8][8];
    int emx = 0, emy = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mb_valid_i && mb_ready_o) acc_cyc = cyc;
        if (!rst && pv && !pr && (!wr_valid_o || wr_addr_o !== pa || wr_data_o !== pd)) stall_err++;
        if (wr_valid_o && wr_ready_i) begin
            q_a.push_back(wr_addr_o);
            q_d.push_back(wr_data_o);
            q_c.push_back(cyc);
        end
        if (mb_done_o) begin done_cnt++; done_cyc = cyc; end
`ifdef H264_WB_FRAME_DONE_EN
        if (frame_done_o) begin fd_cnt++; fd_cyc = cyc; end
`endif
        pv = wr_valid_o; pr = wr_ready_i; pa = wr_addr_o; pd = wr_data_o;
    end

    function automatic logic [31:0] qa(input int k);
        return (q_a.size() > k) ? q_a[k] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] qd(input int k);
        return (q_d.size() > k) ? q_d[k] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] qc(input int k);
        return (q_c.size() > k) ? 32'(q_c[k] - acc_cyc) : 32'hDEAD_BEEF;
    endfunction

    // reference address/data for word k of the macroblock (0..63 Y, 64..79 U, 80..95 V)
    function automatic logic [31:0] m_addr(input int k);
        int r, w, j;
        if (k < 64) begin
            r = k / 4; w = k % 4;
            return 32'((emy * 16 + r) * 352 + emx * 16 + w * 4);
        end
        j = (k - 64) % 16; r = j / 2; w = j % 2;
        return ((k < 80) ? 32'h0001_8C00 : 32'h0001_EF00) + 32'((emy * 8 + r) * 176 + emx * 8 + w * 4);
    endfunction

    function automatic logic [31:0] m_data(input int k);
        int r, w, j;
        if (k < 64) begin
            r = k / 4; w = k % 4;
            return {ey[r][4*w+3], ey[r][4*w+2], ey[r][4*w+1], ey[r][4*w]};
        end
        j = (k - 64) % 16; r = j / 2; w = j % 2;
        if (k < 80) return {eu[r][4*w+3], eu[r][4*w+2], eu[r][4*w+1], eu[r][4*w]};
        return {ev[r][4*w+3], ev[r][4*w+2], ev[r][4*w+1], ev[r][4*w]};
    endfunction

    task automatic fill(input int s);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                dy[r][c] = (s == 0) ? 8'(r * 16 + c) : 8'(r * 37 + c * 11 + s * 53);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                du[r][c] = (s == 0) ? 8'(128 + r * 8 + c) : 8'(r * 19 + c * 5 + s * 71 + 3);
                dv[r][c] = (s == 0) ? 8'(192 + r * 8 + c) : 8'(r * 23 + c * 13 + s * 29 + 7);
            end
    endtask

    task automatic start_mb(input int x, input int y);
        mb_x_i = 6'(x); mb_y_i = 6'(y); emx = x; emy = y;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) ey[r][c] = dy[r][c];
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin eu[r][c] = du[r][c]; ev[r][c] = dv[r][c]; end
        q_a.delete(); q_d.delete(); q_c.delete();
        mb_valid_i = 1;
        @(posedge clk); #1;
        mb_valid_i = 0;
    endtask

    task automatic wait_done(input string tag, input bit bp, input bit inject);
        int d0 = done_cnt, left = 0;
        bit injected = 0;
        for (int n = 0; n < 3000 && done_cnt == d0; n++) begin
            @(posedge clk); #1;
            if (bp) wr_ready_i = 1'($urandom_range(0, 1));
            if (inject && !injected && q_a.size() >= 70) begin
                fill(9); mb_x_i = 5; mb_y_i = 5; mb_valid_i = 1;
                injected = 1; left = 3;
                chk({tag, "_busy_ready"}, 32'(mb_ready_o), 0);
            end else if (left > 0) begin
                left--;
                if (left == 0) mb_valid_i = 0;
            end
        end
        wr_ready_i = 1;
        chk({tag, "_done_seen"}, 32'(done_cnt - d0), 1);
    endtask

    task automatic check_words(input string tag);
        int errs = 0;
        chk({tag, "_count"}, 32'(q_a.size()), 96);
        for (int k = 0; k < 96 && k < q_a.size(); k++)
            if (q_a[k] !== m_addr(k) || q_d[k] !== m_data(k)) errs++;
        chk({tag, "_words"}, 32'(errs), 0);
    endtask

    initial begin
        int dc;
        fill(0);
        repeat (3) @(posedge clk); #1 rst = 0;
        repeat (2) @(posedge clk); #1 rst = 1; #2;
        chk("rst_ready", 32'(mb_ready_o), 1);
        chk("rst_valid", 32'(wr_valid_o), 0);
        chk("rst_addr", wr_addr_o, 0);
        chk("rst_data", wr_data_o, 0);
        chk("rst_done", 32'(mb_done_o), 0);
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1;

        wr_ready_i = 1;
        start_mb(0, 0);
        wait_done("a", 0, 0);
        chk("a_ready_cyc", 32'(cyc - acc_cyc), 98);
        chk("a_ready", 32'(mb_ready_o), 1);
        check_words("a");
        chk("a_addr0", qa(0), 32'h0);
        chk("a_data0", qd(0), 32'h0302_0100);
        chk("a_addr4", qa(4), 32'h160);
        chk("a_data4", qd(4), 32'h1312_1110);
        chk("a_u0_addr", qa(64), 32'h0001_8C00);
        chk("a_u0_data", qd(64), 32'h8382_8180);
        chk("a_v0_addr", qa(80), 32'h0001_EF00);
        chk("a_v0_data", qd(80), 32'hC3C2_C1C0);
        chk("a_first_cyc", qc(0), 1);
        chk("a_u_cyc", qc(64), 65);
        chk("a_last_cyc", qc(95), 96);
        chk("a_done_cyc", 32'(done_cyc - acc_cyc), 97);
`ifdef H264_WB_FRAME_DONE_EN
        chk("a_frame_done", 32'(fd_cnt), 0);
`endif

        fill(1);
        start_mb(21, 17);
        wait_done("b", 0, 0);
        check_words("b");
        chk("b_last_y", qa(63), 32'd101372);
        chk("b_last_v", qa(95), 32'd152060);
`ifdef H264_WB_FRAME_DONE_EN
        chk("b_frame_done", 32'(fd_cnt), 1);
        chk("b_frame_done_cyc", 32'(fd_cyc), 32'(done_cyc));
`endif

        fill(2);
        dc = done_cnt;
        start_mb(7, 4);
        wait_done("c", 1, 0);
        repeat (4) @(posedge clk); #1;
        chk("c_stable", 32'(stall_err), 0);
        chk("c_done_once", 32'(done_cnt - dc), 1);
        check_words("c");

        fill(3);
        dc = done_cnt;
        start_mb(3, 2);
        wait_done("d", 0, 1);
        repeat (4) @(posedge clk); #1;
        chk("d_done_once", 32'(done_cnt - dc), 1);
        check_words("d");

        fill(4);
        start_mb(10, 9);
        for (int n = 0; n < 500 && q_a.size() < 40; n++) begin @(posedge clk); #1; end
        chk("e_reach40", 32'(q_a.size() >= 40), 1);
        dc = done_cnt;
        rst = 1; #1;
        chk("e_valid", 32'(wr_valid_o), 0);
        chk("e_ready", 32'(mb_ready_o), 1);
        chk("e_addr", wr_addr_o, 0);
        chk("e_done", 32'(mb_done_o), 0);
        @(posedge clk); #1 rst = 0;
        repeat (100) @(posedge clk); #1;
        chk("e_no_done", 32'(done_cnt - dc), 0);
        chk("e_idle_ready", 32'(mb_ready_o), 1);

        fill(5);
        start_mb(2, 3);
        wait_done("f", 0, 0);
        check_words("f");
        chk("f_addr0", qa(0), 32'd16928);
        chk("f_first_cyc", qc(0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
